// File: rtl/circ_smpl_buffer_param_pkg.sv
// rtl/circ_smpl_buffer_param_pkg.sv - shared states, defaults and width helpers for the sample buffer
package circ_smpl_buffer_param_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_DEPTH    = 1536;
  localparam int DEF_PRESCALE = 1024;

  // Index width for a range of n values; never below 1 bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width able to hold a count from 0 to n inclusive
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/circ_smpl_buffer_param_dp_ram.sv
// rtl/circ_smpl_buffer_param_dp_ram.sv - simple dual-port RAM, registered read-first read port
module dp_ram_param
  import circ_smpl_buffer_param_pkg::*;
#(
  parameter int WIDTH_W = DEF_WIDTH,
  parameter int DEPTH_W = DEF_DEPTH,
  localparam int AW     = idx_w(DEPTH_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [WIDTH_W-1:0] wr_data,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_addr,
  output logic [WIDTH_W-1:0] rd_data
);

  logic [WIDTH_W-1:0] mem [DEPTH_W];

  // Write port; array has no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port samples the array before the same-edge write lands (read-first)
  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/circ_smpl_buffer_param.sv
// rtl/circ_smpl_buffer_param.sv - prescaled multi-channel circular sample buffer with fill/drain sequencing
module circ_smpl_buffer_param
  import circ_smpl_buffer_param_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CHANNELS  = 1,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int THRESH    = 1020,
  parameter int PRESCALE  = DEF_PRESCALE,
  parameter int OVERWRITE = 0,
  localparam int EW       = CHANNELS * WIDTH,
  localparam int CW       = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [EW-1:0] new_smpl,
  input  logic          wrt_smpl,
  input  logic          clr_ovf,
  output logic [EW-1:0] smpl_out,
  output logic          smpl_vld,
  output logic          sequencing,
  output logic [CW-1:0] fill_cnt,
  output logic          overflow
);

  localparam int AW = idx_w(DEPTH);
  localparam int PW = idx_w(PRESCALE);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C  = CW'(THRESH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [PW-1:0] LAST_PS   = PW'(PRESCALE - 1);
  localparam logic          OVW       = (OVERWRITE != 0);

  logic [PW-1:0] ps_cnt;
  logic          tick;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  state_t        state;
  state_t        state_next;
  logic          full;
  logic          wr_req;
  logic          wr_acc;
  logic          rd_acc;
  logic          rd_adv;
  logic [CW-1:0] fill_next;

  // Pointer advance with wrap for non power-of-two depths
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + 1'b1;
  endfunction

  assign tick   = (ps_cnt == LAST_PS);
  assign full   = (fill_cnt == DEPTH_C);
  assign wr_req = tick & wrt_smpl;
  assign wr_acc = wr_req & (~full | OVW);
  assign rd_acc = tick & (state == ST_DRAIN) & (fill_cnt != '0);
  // A write into a full buffer in overwrite mode discards the oldest entry
  assign rd_adv = rd_acc | (wr_acc & full);

  // Prescaler: one tick every PRESCALE clocks
  always_ff @(posedge clk) begin
    if (rst)       ps_cnt <= '0;
    else if (tick) ps_cnt <= '0;
    else           ps_cnt <= ps_cnt + 1'b1;
  end

  // Occupancy after this cycle's accepted write/read
  always_comb begin
    fill_next = fill_cnt;
    if (wr_acc && !rd_acc && !full) fill_next = fill_cnt + 1'b1;
    else if (!wr_acc && rd_acc)     fill_next = fill_cnt - 1'b1;
  end

  // Next state from post-update occupancy
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (wr_acc) state_next = ST_FILL;
      ST_FILL:  if (fill_next >= THRESH_C) state_next = ST_DRAIN;
      ST_DRAIN: if (fill_next == '0) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State, sequencing flag and read strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      sequencing <= 1'b0;
      smpl_vld   <= 1'b0;
    end else begin
      state      <= state_next;
      sequencing <= (state_next == ST_DRAIN);
      smpl_vld   <= rd_acc;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill_cnt <= '0;
    end else begin
      if (wr_acc) wr_ptr <= next_ptr(wr_ptr);
      if (rd_adv) rd_ptr <= next_ptr(rd_ptr);
      fill_cnt <= fill_next;
    end
  end

  // Sticky overflow; a new overflow beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst)                 overflow <= 1'b0;
    else if (wr_req && full) overflow <= 1'b1;
    else if (clr_ovf)        overflow <= 1'b0;
  end

  dp_ram_param #(
    .WIDTH_W (EW),
    .DEPTH_W (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (new_smpl),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (smpl_out)
  );

endmodule
